mat_vec_mac: RTL and testbench
==============================

MAT_VEC_MAC -- requirements
Module: mat_vec_mac

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8, which is the operand width.
REQ-002 The block SHALL have the parameter ROWS, default 8, which is the number of A rows and MAC lanes.
REQ-003 The block SHALL have the parameter COLS, default 8, which is the number of products accumulated per row.
REQ-004 The block SHALL have the parameter ACC_WIDTH, default 24, which is the accumulator width; it SHALL be at least 2*DATA_WIDTH+$clog2(COLS).
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be on posedge clk.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port start_mult, input, 1 bit: the upstream FIFO read strobe; A_data and B_data SHALL be valid one cycle later.
REQ-008 The block SHALL have the port stop, input, 1 bit: upstream row-0 FIFO empty.
REQ-009 The block SHALL have the port A_data, input, ROWS x DATA_WIDTH: skewed A row outputs, with row i lagging row 0 by i cycles.
REQ-010 The block SHALL have the port B_data, input, DATA_WIDTH: the B vector element stream.
REQ-011 The block SHALL have the port clear, input, 1 bit: synchronous return from DONE/ERR to IDLE that also zeroes the accumulators.
REQ-012 The block SHALL have the port C_data, output, ROWS x ACC_WIDTH: the result vector.
REQ-013 The block SHALL have the port done, output, 1 bit: high while in DONE.
REQ-014 The block SHALL have the port underflow, output, 1 bit: high while in ERR.
REQ-015 The block SHALL have the port state_out, output, 3 bits: the current state encoding.

Function
REQ-016 The block SHALL implement the states IDLE, RUN, DRAIN, DONE and ERR.
REQ-017 The valid pipe SHALL operate as v[0] <= start_mult and v[i] <= v[i-1] for i in 1..ROWS-1.
REQ-018 The B pipe SHALL capture bp[0] <= B_data when v[0] is high and SHALL shift bp[i] <= bp[i-1] each cycle.
REQ-019 Lane i SHALL perform acc[i] += A_data[i]*bp[i] in each cycle where v[i] is high and its count cnt[i] < COLS, and SHALL increment cnt[i] on each such cycle.
REQ-020 Products SHALL be 2*DATA_WIDTH bits wide and SHALL be zero-extended to ACC_WIDTH; no overflow is possible by construction.
REQ-021 The state machine SHALL go IDLE->RUN on start_mult=1; the first product is lane 0, one cycle later.
REQ-022 The state machine SHALL go RUN->DRAIN when cnt[0] reaches COLS.
REQ-023 The state machine SHALL go DRAIN->DONE when cnt[ROWS-1] reaches COLS.
REQ-024 With start_mult held continuously, done SHALL rise COLS+ROWS cycles after the first start_mult cycle, which is 16 cycles at the defaults.
REQ-025 When start_mult=0 during RUN (a bubble), lanes SHALL hold their acc and cnt; the bubble SHALL propagate through v[] and SHALL extend latency by one cycle per bubble.
REQ-026 The state machine SHALL go RUN->ERR when stop=1 while cnt[0] < COLS and start_mult=0; accumulators SHALL then freeze.
REQ-027 A start_mult asserted in DONE or ERR SHALL be ignored.
REQ-028 In DONE, C_data SHALL be stable and equal to acc.
REQ-029 The state machine SHALL go DONE->IDLE and ERR->IDLE on clear=1; clear SHALL zero acc, cnt, v and bp in the same edge.
REQ-030 If clear and start_mult are both high in DONE, clear SHALL win; start_mult SHALL be re-sampled in IDLE on the next cycle.
REQ-031 clear SHALL have no effect in IDLE, RUN or DRAIN.
REQ-032 C_data SHALL be driven directly from acc and SHALL be valid only when done=1.

Reset
REQ-033 reset=1 SHALL asynchronously force the state to IDLE and set acc, cnt, v and bp to 0.
REQ-034 During reset, C_data, done and underflow SHALL be 0, and state_out SHALL be the IDLE encoding.
REQ-035 A reset mid-RUN/DRAIN SHALL discard the partial results; after reset is released, the block SHALL wait for a new start_mult.

Configuration
REQ-036 The macro MAT_VEC_MAC_SIGNED_EN SHALL select operand signedness.
REQ-037 When MAT_VEC_MAC_SIGNED_EN is defined, A_data, B_data and the products SHALL be two's complement, and products SHALL be sign-extended to ACC_WIDTH.
REQ-038 When MAT_VEC_MAC_SIGNED_EN is undefined, all arithmetic SHALL be unsigned, as in REQ-020.

Structure
REQ-039 The package mat_vec_mac_pkg SHALL hold the state enum mac_state_t (3-bit) and the default DATA_WIDTH, ROWS, COLS and ACC_WIDTH constants.
REQ-040 The sub-module mac_unit SHALL implement one lane: the multiply, the accumulate, cnt, and the synchronous clear, parameterised by DATA_WIDTH, ACC_WIDTH and COLS.
REQ-041 mat_vec_mac SHALL instantiate ROWS mac_unit lanes in a generate loop and SHALL own the FSM, the v pipe and the bp pipe.

Verification
REQ-042 Scenario: A all 1, B=1..8, start_mult held 8 cycles -> every C_data[i]=36, and done rises at cycle 16.
REQ-043 Scenario: A row i = i+1 constant, B all 2 -> C_data[i]=16*(i+1).
REQ-044 Scenario: all operands 255, unsigned build -> every C_data[i]=520200 with no wrap.
REQ-045 Scenario: the REQ-042 stimulus with start_mult low for 3 cycles after the 4th element -> same results, with done at cycle 19.
REQ-046 Scenario: stop=1 with start_mult=0 after 5 elements -> underflow=1 and state ERR; then clear -> IDLE with C_data=0.
REQ-047 Scenario: reset pulse during DRAIN -> all outputs 0; a following REQ-042 run SHALL yield C_data[i]=36.

Source files
------------

// File: rtl/mat_vec_mac_pkg.sv
// mat_vec_mac_pkg: shared types and default sizes for the matrix-vector MAC.
//   mac_state_t      - 3-bit FSM state encoding, visible on state_out
//   Default*         - default DATA_WIDTH / ROWS / COLS / ACC_WIDTH values
package mat_vec_mac_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultRows      = 8;
    localparam int unsigned DefaultCols      = 8;
    localparam int unsigned DefaultAccWidth  = 24;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } mac_state_t;

endpackage

// File: rtl/mat_vec_mac_mac_unit.sv
// mac_unit: one MAC lane. Accumulates a_i*b_i on each enabled cycle until COLS
// products have been summed, then holds.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   en_i         - operands valid for this lane this cycle
//   clr_i        - synchronous clear of accumulator and count
//   a_i, b_i     - operands
//   acc_o        - running sum
//   full_o       - COLS products accumulated
// Build option: define MAT_VEC_MAC_SIGNED_EN for two's complement operands
// with sign-extended products; otherwise unsigned with zero extension.
module mac_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned COLS       = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  full_o
);

    localparam int unsigned CntW  = $clog2(COLS + 1);
    localparam int unsigned ProdW = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ProdW-1:0]     prod;
    logic [ACC_WIDTH-1:0] prod_ext;

`ifdef MAT_VEC_MAC_SIGNED_EN
    assign prod = $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i})
                * $signed({{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i});
    assign prod_ext = {{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod};
`else
    assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    assign prod_ext = {{(ACC_WIDTH - ProdW){1'b0}}, prod};
`endif

    assign full_o = (cnt_q == CntW'(COLS));
    assign acc_o  = acc_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en_i && !full_o) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mat_vec_mac.sv
// mat_vec_mac: ROWS-lane matrix-vector multiply-accumulate fed by skewed A rows.
//   clk, reset  - clock, asynchronous active-high reset
//   start_mult  - upstream read strobe; A_data/B_data valid one cycle later
//   stop        - upstream row-0 FIFO empty
//   A_data      - ROWS operands, row i lagging row 0 by i cycles
//   B_data      - B vector element stream
//   clear       - leave DONE/ERR for IDLE and zero the lanes
//   C_data      - result vector (valid while done)
//   done        - high in DONE
//   underflow   - high in ERR
//   state_out   - current state encoding
// Build option: MAT_VEC_MAC_SIGNED_EN selects signed arithmetic in the lanes.
module mat_vec_mac
    import mat_vec_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ROWS       = DefaultRows,
    parameter int unsigned COLS       = DefaultCols,
    parameter int unsigned ACC_WIDTH  = DefaultAccWidth
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_mult,
    input  logic                                stop,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]     A_data,
    input  logic [DATA_WIDTH-1:0]               B_data,
    input  logic                                clear,
    output logic [ROWS-1:0][ACC_WIDTH-1:0]      C_data,
    output logic                                done,
    output logic                                underflow,
    output logic [2:0]                          state_out
);

    // Lane 0 takes B_data straight off the bus; lane i takes the B pipe stage
    // captured i-1 cycles earlier, which lines it up with the skewed A row.
    localparam int unsigned BpDepth = (ROWS > 1) ? ROWS - 1 : 1;

    mac_state_t state_q, state_d;
    logic [ROWS-1:0]                      v_q, v_d;
    logic [BpDepth-1:0][DATA_WIDTH-1:0]   bp_q, bp_d;
    logic [ROWS-1:0]                      full;
    logic                                 clr_ok;
    logic                                 accept_start;
    logic                                 lanes_run;

    assign clr_ok       = clear && (state_q == StDone || state_q == StErr);
    assign accept_start = start_mult
                        && (state_q == StIdle || state_q == StRun || state_q == StDrain);
    // Lanes freeze once an underflow has been flagged.
    assign lanes_run    = (state_q != StErr);

    // ---------------- valid and B pipes ----------------
    always_comb begin
        v_d    = v_q;
        bp_d   = bp_q;
        v_d[0] = accept_start;
        for (int i = 1; i < int'(ROWS); i++) begin
            v_d[i] = v_q[i-1];
        end
        if (v_q[0]) begin
            bp_d[0] = B_data;
        end
        for (int i = 1; i < int'(BpDepth); i++) begin
            bp_d[i] = bp_q[i-1];
        end
        if (clr_ok) begin
            v_d  = '0;
            bp_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q  <= '0;
            bp_q <= '0;
        end else begin
            v_q  <= v_d;
            bp_q <= bp_d;
        end
    end

    // ---------------- lanes ----------------
    for (genvar i = 0; i < int'(ROWS); i++) begin : g_lane
        logic [DATA_WIDTH-1:0] b_op;
        if (i == 0) begin : g_head
            assign b_op = B_data;
        end else begin : g_tail
            assign b_op = bp_q[i-1];
        end

        mac_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .COLS       (COLS)
        ) u_mac (
            .clk_i  (clk),
            .rst_i  (reset),
            .en_i   (v_q[i] && lanes_run),
            .clr_i  (clr_ok),
            .a_i    (A_data[i]),
            .b_i    (b_op),
            .acc_o  (C_data[i]),
            .full_o (full[i])
        );
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_mult) state_d = StRun;
            StRun: begin
                if (full[0]) begin
                    state_d = StDrain;
                end else if (stop && !start_mult) begin
                    state_d = StErr;
                end
            end
            // Lanes fill in order, so all full is the same as the last lane full.
            StDrain: if (&full) state_d = StDone;
            StDone:  if (clear) state_d = StIdle;
            StErr:   if (clear) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done      = (state_q == StDone);
        underflow = (state_q == StErr);
        state_out = state_q;
    end

endmodule

// File: tb/tb_mat_vec_mac.sv
module tb_mat_vec_mac;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int NC = 8;
    localparam int AW = 24;
    localparam int NREC = 6;

    logic clk = 1'b0;
    logic reset, start_mult, stop, clear;
    logic [NR-1:0][DW-1:0] a_data;
    logic [DW-1:0]         b_data;
    logic [NR-1:0][AW-1:0] c_data;
    logic                  done, underflow;
    logic [2:0]            state_out;

    always #5 clk = ~clk;

    mat_vec_mac #(
        .DATA_WIDTH (DW),
        .ROWS       (NR),
        .COLS       (NC),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .stop       (stop),
        .A_data     (a_data),
        .B_data     (b_data),
        .clear      (clear),
        .C_data     (c_data),
        .done       (done),
        .underflow  (underflow),
        .state_out  (state_out)
    );

    typedef struct {
        int     a[NR][NC];
        int     b[NC];
        int     gap_len;     // start_mult low for this many cycles after element 4
        bit     clr_in_run;  // hold clear high through the run (must be ignored)
        int     exp_done;    // cycle of done rise, first start_mult cycle = 0
        longint exp_c[NR];
    } rec_t;

    rec_t tbl[NREC];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur_a[NR][NC];
    int   cur_b[NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Operand value as the arithmetic sees it.
    function automatic longint opv(input int x);
`ifdef MAT_VEC_MAC_SIGNED_EN
        logic signed [7:0] s;
        s = x[7:0];
        return longint'(s);
`else
        return longint'(x & 255);
`endif
    endfunction

    function automatic longint wrap_acc(input longint v);
        logic [AW-1:0] t;
        t = v[AW-1:0];
        return longint'(t);
    endfunction

    // Reference: row i of A dotted with B.
    function automatic longint dot(input int row);
        longint s = 0;
        for (int k = 0; k < NC; k++) s += opv(cur_a[row][k]) * opv(cur_b[k]);
        return wrap_acc(s);
    endfunction

    task automatic load(input int r);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < NC; k++) cur_a[i][k] = tbl[r].a[i][k];
        for (int k = 0; k < NC; k++) cur_b[k] = tbl[r].b[k];
    endtask

    // Upstream FIFO model: element k is read on a start_mult cycle c, then B[k]
    // appears in cycle c+1 and row i's A[i][k] in cycle c+1+i. Non-valid slots
    // carry random junk. Stops early once done is seen.
    task automatic run_job(input int gap_len, input bit clr_run, input int err_at,
                           input int ncyc, output int done_cyc);
        int hist[0:255];
        int k = 0;
        int gap_left = gap_len;
        done_cyc = -1;
        for (int c = 0; c < 256; c++) hist[c] = -1;
        for (int c = 0; c < ncyc; c++) begin
            start_mult = 1'b0;
            stop       = 1'b0;
            clear      = clr_run;
            if (err_at >= 0 && k == err_at) begin
                stop = 1'b1;
            end else if (k == 4 && gap_left > 0) begin
                gap_left--;
            end else if (k < NC) begin
                start_mult = 1'b1;
                hist[c]    = k;
                k++;
            end
            b_data = DW'($urandom);
            if (c >= 1) begin
                if (hist[c-1] >= 0) b_data = DW'(cur_b[hist[c-1]]);
            end
            for (int i = 0; i < NR; i++) begin
                a_data[i] = DW'($urandom);
                if (c - 1 - i >= 0) begin
                    if (hist[c-1-i] >= 0) a_data[i] = DW'(cur_a[i][hist[c-1-i]]);
                end
            end
            step();
            if (done && done_cyc < 0) begin
                done_cyc = c;
                break;
            end
        end
        start_mult = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic fill_table();
        for (int r = 0; r < NREC; r++) begin
            tbl[r].gap_len    = 0;
            tbl[r].clr_in_run = 1'b0;
            tbl[r].exp_done   = NC + NR;
        end
        // A all 1, B = 1..8 -> 36
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < NC; k++) tbl[0].a[i][k] = 1;
            tbl[0].exp_c[i] = 36;
        end
        for (int k = 0; k < NC; k++) tbl[0].b[k] = k + 1;
        // A row i = i+1, B all 2 -> 16*(i+1)
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < NC; k++) tbl[1].a[i][k] = i + 1;
            tbl[1].exp_c[i] = 16 * (i + 1);
        end
        for (int k = 0; k < NC; k++) tbl[1].b[k] = 2;
        // all 255
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < NC; k++) tbl[2].a[i][k] = 255;
`ifdef MAT_VEC_MAC_SIGNED_EN
            tbl[2].exp_c[i] = 8;
`else
            tbl[2].exp_c[i] = 520200;
`endif
        end
        for (int k = 0; k < NC; k++) tbl[2].b[k] = 255;
        // first vector again with a 3-cycle bubble
        tbl[3] = tbl[0];
        tbl[3].gap_len  = 3;
        tbl[3].exp_done = NC + NR + 3;
        // random operands, expected values from the reference
        for (int r = 4; r < NREC; r++) begin
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < NC; k++) tbl[r].a[i][k] = int'($urandom_range(0, 255));
            for (int k = 0; k < NC; k++) tbl[r].b[k] = int'($urandom_range(0, 255));
            load(r);
            for (int i = 0; i < NR; i++) tbl[r].exp_c[i] = dot(i);
        end
        tbl[5].gap_len    = 2;
        tbl[5].exp_done   = NC + NR + 2;
        tbl[5].clr_in_run = 1'b1;
    endtask

    initial begin
        int dcyc;
        logic [NR-1:0][AW-1:0] snap;

        reset = 1'b1; start_mult = 1'b0; stop = 1'b0; clear = 1'b0;
        a_data = '0; b_data = '0;
        fill_table();
        repeat (2) step();
        check("rst_c_zero", 64'(|c_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_state", 64'(state_out), 64'd0);
        reset = 1'b0;
        step();

        for (int r = 0; r < NREC; r++) begin
            load(r);
            run_job(tbl[r].gap_len, tbl[r].clr_in_run, -1, 64, dcyc);
            check($sformatf("rec%0d_done_cycle", r), 64'(dcyc), 64'(tbl[r].exp_done));
            for (int i = 0; i < NR; i++)
                check($sformatf("rec%0d_c%0d", r, i), 64'(c_data[i]), 64'(tbl[r].exp_c[i]));
            check($sformatf("rec%0d_state_done", r), 64'(state_out), 64'd3);
            // start_mult in DONE is ignored; result must hold
            snap = c_data;
            start_mult = 1'b1;
            repeat (3) step();
            check($sformatf("rec%0d_done_hold", r), 64'(state_out), 64'd3);
            check($sformatf("rec%0d_c_stable", r), 64'(c_data == snap), 64'd1);
            start_mult = 1'b0;
            clear = 1'b1;
            step();
            clear = 1'b0;
            check($sformatf("rec%0d_clr_state", r), 64'(state_out), 64'd0);
            check($sformatf("rec%0d_clr_c_zero", r), 64'(|c_data), 64'd0);
        end

        // Underflow: FIFO runs dry after 5 elements.
        load(0);
        run_job(0, 1'b0, 5, 10, dcyc);
        check("err_underflow", 64'(underflow), 64'd1);
        check("err_state", 64'(state_out), 64'd4);
        check("err_done_low", 64'(done), 64'd0);
        check("err_c0_partial", 64'(c_data[0]), 64'd15);
        snap = c_data;
        start_mult = 1'b1;
        repeat (3) step();
        start_mult = 1'b0;
        check("err_start_ignored", 64'(state_out), 64'd4);
        check("err_acc_frozen", 64'(c_data == snap), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("err_clr_state", 64'(state_out), 64'd0);
        check("err_clr_underflow", 64'(underflow), 64'd0);
        check("err_clr_c_zero", 64'(|c_data), 64'd0);

        // Reset during DRAIN discards the partial job.
        load(0);
        run_job(0, 1'b0, -1, 12, dcyc);
        check("drain_state", 64'(state_out), 64'd2);
        reset = 1'b1;
        #1;
        check("drain_rst_c_zero", 64'(|c_data), 64'd0);
        check("drain_rst_state", 64'(state_out), 64'd0);
        check("drain_rst_flags", 64'({done, underflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        check("post_rst_waits", 64'(state_out), 64'd0);
        run_job(0, 1'b0, -1, 64, dcyc);
        check("post_rst_done_cycle", 64'(dcyc), 64'(NC + NR));
        for (int i = 0; i < NR; i++)
            check($sformatf("post_rst_c%0d", i), 64'(c_data[i]), 64'd36);

        // clear wins over start_mult in DONE; start is re-sampled in IDLE.
        clear = 1'b1;
        start_mult = 1'b1;
        step();
        clear = 1'b0;
        check("clr_wins_state", 64'(state_out), 64'd0);
        check("clr_wins_c_zero", 64'(|c_data), 64'd0);
        step();
        start_mult = 1'b0;
        check("resample_run", 64'(state_out), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
